// File: rtl/alu_seq.sv
// alu_seq: sequencer driving an external combinational ALU through a one-cycle
// EXEC state and an optional N-cycle shift-add MUL state.
// Ports: clk, rst_n (sync, active-low); cmd_valid/cmd_ready/cmd_op/cmd_data
// command handshake; alu_a/alu_b/alu_cin/alu_cs to the ALU, alu_s/alu_zero/
// alu_cout from it; acc/acc_hi/flag_z/flag_c architectural state; done/err
// one-cycle completion pulses; busy = !cmd_ready.
// Build option: define ALU_SEQ_MUL_EN to include MUL (opcode 8) and acc_hi;
// without it opcode 8 is illegal and acc_hi reads 0.
module alu_seq #(
  parameter int N    = 8,
  parameter int AC_N = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [N-1:0]    cmd_data,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic            alu_cin,
  output logic [AC_N-1:0] alu_cs,
  input  logic [N-1:0]    alu_s,
  input  logic            alu_zero,
  input  logic            alu_cout,
  output logic [N-1:0]    acc,
  output logic [N-1:0]    acc_hi,
  output logic            flag_z,
  output logic            flag_c,
  output logic            done,
  output logic            err,
  output logic            busy
);
  localparam logic [AC_N-1:0] AC_AD = AC_N'(0);
  localparam logic [AC_N-1:0] AC_SB = AC_N'(1);
  localparam logic [AC_N-1:0] AC_AN = AC_N'(2);
  localparam logic [AC_N-1:0] AC_OR = AC_N'(3);
  localparam logic [AC_N-1:0] AC_LS = AC_N'(4);
  localparam logic [3:0] OP_LD  = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SBC = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_LT  = 4'd7;
  typedef enum logic [1:0] {
    IDLE,
`ifdef ALU_SEQ_MUL_EN
    MUL,
`endif
    EXEC
  } state_t;
  state_t state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [N-1:0] opd_q, opd_d, acc_q, acc_d;
  logic         fz_q, fz_d, fc_q, fc_d, done_q, done_d, err_q, err_d;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  logic [N-1:0]  hi_q, hi_d, lo_q, lo_d, mul_h;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mul_c;
  assign acc_hi = hi_q;
`else
  assign acc_hi = '0;
`endif
  assign cmd_ready = (state_q == IDLE);
  assign busy      = !cmd_ready;
  assign acc       = acc_q;
  assign flag_z    = fz_q;
  assign flag_c    = fc_q;
  assign done      = done_q;
  assign err       = err_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opd_d   = opd_q;
    acc_d   = acc_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_cs  = AC_AD;
`ifdef ALU_SEQ_MUL_EN
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    mul_c   = 1'b0;
    mul_h   = hi_q;
`endif
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        opd_d   = cmd_data;
        state_d = EXEC;
`ifdef ALU_SEQ_MUL_EN
        if (cmd_op == OP_MUL) begin
          state_d = MUL;
          hi_d    = '0;
          lo_d    = acc_q;
          cnt_d   = '0;
        end
`endif
      end
      EXEC: begin
        alu_a   = acc_q;
        alu_b   = opd_q;
        alu_cs  = (op_q == OP_SUB || op_q == OP_SBC) ? AC_SB :
                  (op_q == OP_AND) ? AC_AN :
                  (op_q == OP_OR)  ? AC_OR :
                  (op_q == OP_LT)  ? AC_LS : AC_AD;
        alu_cin = (op_q == OP_ADC || op_q == OP_SBC) && fc_q;
        state_d = IDLE;
        done_d  = 1'b1;
        if (op_q == OP_LD) begin
          acc_d = opd_q;
          fz_d  = (opd_q == '0);
        end else if (op_q <= OP_LT) begin
          acc_d = alu_s;
          fz_d  = alu_zero;
          // only the add/subtract family produces a carry/borrow
          fc_d  = (op_q <= OP_SBC) && alu_cout;
        end else begin
          err_d = 1'b1;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        alu_a = hi_q;
        alu_b = opd_q;
        {mul_c, mul_h} = lo_q[0] ? {alu_cout, alu_s} : {1'b0, hi_q};
        {hi_d, lo_d}   = {mul_c, mul_h, lo_q[N-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          acc_d   = lo_d;
          fc_d    = |hi_d;
          fz_d    = (lo_d == '0);
          cnt_d   = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      opd_q   <= '0;
      acc_q   <= '0;
      fz_q    <= 1'b1;
      fc_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opd_q   <= opd_d;
      acc_q   <= acc_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef ALU_SEQ_MUL_EN
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq with a behavioural ALU attached;
// directed vector table, busy/reset sequences and random commands against a
// plain-arithmetic reference model. Adapts to ALU_SEQ_MUL_EN.
module tb_alu_seq;
  localparam int N = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam logic [2:0] AC_AD = 3'd0, AC_SB = 3'd1, AC_AN = 3'd2, AC_OR = 3'd3, AC_LS = 3'd4;
  logic clk, rst_n, cmd_valid, cmd_ready, alu_cin, alu_zero, alu_cout;
  logic flag_z, flag_c, done, err, busy;
  logic [3:0] cmd_op;
  logic [2:0] alu_cs;
  logic [N-1:0] cmd_data, alu_a, alu_b, alu_s, acc, acc_hi;
  alu_seq #(.N(N), .AC_N(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_cs(alu_cs), .alu_s(alu_s), .alu_zero(alu_zero),
    .alu_cout(alu_cout), .acc(acc), .acc_hi(acc_hi), .flag_z(flag_z),
    .flag_c(flag_c), .done(done), .err(err), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // external ALU: cout is carry for add, borrow for subtract
  always_comb begin
    {alu_cout, alu_s} = 9'd0;
    case (alu_cs)
      AC_AD: {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      AC_SB: {alu_cout, alu_s} = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
      AC_AN: alu_s = alu_a & alu_b;
      AC_OR: alu_s = alu_a | alu_b;
      AC_LS: alu_s = (alu_a < alu_b) ? 8'd1 : 8'd0;
      default: alu_s = 8'd0;
    endcase
    alu_zero = (alu_s == 8'd0);
  end
  typedef struct {
    logic [3:0] op;
    logic [7:0] d, acc, hi;
    bit fz, fc, err;
  } vec_t;
  vec_t tv[$];
  int checks = 0, failures = 0;
  logic [7:0] m_acc = 8'd0, m_hi = 8'd0;
  bit m_fz = 1'b1, m_fc = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic add(input logic [3:0] op, input logic [7:0] d, input logic [7:0] a,
                     input logic [7:0] h, input bit fz, input bit fc, input bit e);
    tv.push_back('{op, d, a, h, fz, fc, e});
  endtask
  task automatic model(input logic [3:0] op, input logic [7:0] d, output bit e, output int lat);
    int a, b, r;
    a = int'(m_acc);
    b = int'(d);
    r = 0;
    e = 1'b0;
    lat = 1;
    case (op)
      4'd0: m_acc = d;
      4'd1: begin r = a + b; m_fc = (r > 255); m_acc = 8'(r); end
      4'd2: begin r = a + b + int'(m_fc); m_fc = (r > 255); m_acc = 8'(r); end
      4'd3: begin r = a - b; m_fc = (r < 0); m_acc = 8'(r); end
      4'd4: begin r = a - b - int'(m_fc); m_fc = (r < 0); m_acc = 8'(r); end
      4'd5: begin m_acc = 8'(a & b); m_fc = 1'b0; end
      4'd6: begin m_acc = 8'(a | b); m_fc = 1'b0; end
      4'd7: begin m_acc = (a < b) ? 8'd1 : 8'd0; m_fc = 1'b0; end
      4'd8: if (MUL_EN) begin
        r = a * b;
        m_acc = 8'(r);
        m_hi = 8'(r >> 8);
        m_fc = (m_hi != 8'd0);
        lat = N;
      end else e = 1'b1;
      default: e = 1'b1;
    endcase
    if (!e) m_fz = (m_acc == 8'd0);
  endtask
  task automatic issue(input logic [3:0] op, input logic [7:0] d, input bit hold,
                       input logic [7:0] eacc, input logic [7:0] ehi, input bit efz,
                       input bit efc, input bit eerr, input int elat, input string tag);
    int lat, busy_n;
    chk({tag, " ready_in"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    @(negedge clk);
    chk({tag, " done_early"}, 32'(done), 32'd0);
    lat = 0;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (!cmd_ready) busy_n++;
      cmd_valid = hold;
      cmd_op = 4'($urandom);
      cmd_data = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    cmd_valid = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(elat));
    chk({tag, " ready_done"}, 32'(cmd_ready), 32'd1);
    chk({tag, " acc"}, 32'(acc), 32'(eacc));
    chk({tag, " acc_hi"}, 32'(acc_hi), 32'(ehi));
    chk({tag, " flag_z"}, 32'(flag_z), 32'(efz));
    chk({tag, " flag_c"}, 32'(flag_c), 32'(efc));
    chk({tag, " err"}, 32'(err), 32'(eerr));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bit e;
    int lat, dn;
    logic [3:0] op;
    logic [7:0] d;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 4'd0;
    cmd_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst acc", 32'(acc), 32'd0);
    chk("rst acc_hi", 32'(acc_hi), 32'd0);
    chk("rst flag_z", 32'(flag_z), 32'd1);
    chk("rst flag_c", 32'(flag_c), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    add(4'd0, 8'hF0, 8'hF0, 8'h00, 0, 0, 0);
    add(4'd1, 8'h20, 8'h10, 8'h00, 0, 1, 0);
    add(4'd2, 8'h00, 8'h11, 8'h00, 0, 0, 0);
    add(4'd3, 8'h11, 8'h00, 8'h00, 1, 0, 0);
    add(4'd4, 8'h01, 8'hFF, 8'h00, 0, 1, 0);
    add(4'd4, 8'h00, 8'hFE, 8'h00, 0, 0, 0);
    add(4'd5, 8'h0F, 8'h0E, 8'h00, 0, 0, 0);
    add(4'd6, 8'hF0, 8'hFE, 8'h00, 0, 0, 0);
    add(4'd7, 8'hFF, 8'h01, 8'h00, 0, 0, 0);
    add(4'd7, 8'h01, 8'h00, 8'h00, 1, 0, 0);
    add(4'd0, 8'h0D, 8'h0D, 8'h00, 0, 0, 0);
    add(4'd8, 8'h0B, MUL_EN ? 8'h8F : 8'h0D, 8'h00, 0, 0, !MUL_EN);
    add(4'd0, 8'hFF, 8'hFF, 8'h00, 0, 0, 0);
    add(4'd8, 8'hFF, MUL_EN ? 8'h01 : 8'hFF, MUL_EN ? 8'hFE : 8'h00, 0, MUL_EN, !MUL_EN);
    add(4'd15, 8'h12, MUL_EN ? 8'h01 : 8'hFF, MUL_EN ? 8'hFE : 8'h00, 0, MUL_EN, 1);
    add(4'd0, 8'h07, 8'h07, MUL_EN ? 8'hFE : 8'h00, 0, MUL_EN, 0);
    add(4'd8, 8'h03, MUL_EN ? 8'h15 : 8'h07, 8'h00, 0, 0, !MUL_EN);
    add(4'd1, 8'hF9, MUL_EN ? 8'h0E : 8'h00, 8'h00, !MUL_EN, 1, 0);
    add(4'd0, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    add(4'd8, 8'h55, 8'h00, 8'h00, 1, !MUL_EN, !MUL_EN);
    for (int i = 0; i < tv.size(); i++) begin
      model(tv[i].op, tv[i].d, e, lat);
      issue(tv[i].op, tv[i].d, (i % 3) == 0, tv[i].acc, tv[i].hi, tv[i].fz, tv[i].fc,
            tv[i].err, lat, $sformatf("vec%0d", i));
    end
    // MUL with cmd_valid held high and opcode churning while busy
    model(4'd0, 8'h0D, e, lat);
    issue(4'd0, 8'h0D, 1'b0, m_acc, m_hi, m_fz, m_fc, e, lat, "hold_ld");
    model(4'd8, 8'h0B, e, lat);
    issue(4'd8, 8'h0B, 1'b1, m_acc, m_hi, m_fz, m_fc, e, lat, "hold_mul");
    // reset in the middle of a multiply
    model(4'd0, 8'h33, e, lat);
    issue(4'd0, 8'h33, 1'b0, m_acc, m_hi, m_fz, m_fc, e, lat, "mrst_ld");
    cmd_valid = 1'b1;
    cmd_op = 4'd8;
    cmd_data = 8'h21;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = 8'd0;
    m_hi = 8'd0;
    m_fz = 1'b1;
    m_fc = 1'b0;
    chk("mrst acc", 32'(acc), 32'd0);
    chk("mrst acc_hi", 32'(acc_hi), 32'd0);
    chk("mrst flag_z", 32'(flag_z), 32'd1);
    chk("mrst flag_c", 32'(flag_c), 32'd0);
    chk("mrst ready", 32'(cmd_ready), 32'd1);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || err) dn++;
      @(negedge clk);
    end
    chk("mrst no_done", 32'(dn), 32'd0);
    model(4'd0, 8'h05, e, lat);
    issue(4'd0, 8'h05, 1'b0, 8'h05, 8'h00, 0, 0, 0, 1, "mrst_ld5");
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      d = 8'($urandom);
      model(op, d, e, lat);
      issue(op, d, 1'($urandom_range(0, 1)), m_acc, m_hi, m_fz, m_fc, e, lat,
            $sformatf("rnd%0d op%0d", i, op));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter N, default 8, meaning datapath width; must match the driven alu instance.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when valid and ready both high at a rising edge.
REQ-006 SHALL have port cmd_op  input  4  opcode: 0 LD, 1 ADD, 2 ADC, 3 SUB, 4 SBC, 5 AND, 6 OR, 7 LT, 8 MUL, 9-15 illegal.
REQ-007 SHALL have port cmd_data  input  N  operand B.
REQ-008 SHALL have ports alu_a, alu_b  output  N each; alu_cin  output  1; alu_cs  output  AC_N, using the AC_* codes from ALU_INTERFACE.v.
REQ-009 SHALL have ports alu_s  input  N; alu_zero  input  1; alu_cout  input  1.
REQ-010 SHALL have ports acc, acc_hi  output  N each; flag_z, flag_c  output  1 each; done, err  output  1 each (one-cycle pulses); busy  output  1.

Function
REQ-011 SHALL implement states IDLE, EXEC, MUL; cmd_ready = (state==IDLE); busy = !cmd_ready.
REQ-012 On accept SHALL latch cmd_op and cmd_data; go to MUL for op 8 (when compiled in), else to EXEC.
REQ-013 ALU outputs SHALL be driven only from registers: alu_a=acc, alu_b=latched operand in EXEC; AC_AD with alu_a=acc_hi, alu_cin=0 in MUL; AC_AD with zeros in IDLE.
REQ-014 EXEC SHALL last exactly one cycle; at its closing edge acc<=alu_s, flag_z<=alu_zero, flag_c<=alu_cout; state returns to IDLE.
REQ-015 Opcode mapping: ADD AC_AD cin 0; ADC AC_AD cin flag_c; SUB AC_SB cin 0; SBC AC_SB cin flag_c; AND AC_AN; OR AC_OR; LT AC_LS (acc=1 if acc<operand unsigned); AND/OR/LT leave flag_c=0.
REQ-016 LD SHALL set acc<=operand, flag_z<=(operand==0), leave flag_c and acc_hi unchanged; ALU result ignored.
REQ-017 Illegal opcode SHALL change no acc/acc_hi/flag state, pulse err with done.
REQ-018 done SHALL be high exactly one cycle, in the cycle following the edge that commits results; accept at edge T0 -> commit T1 -> done in cycle T1..T2; next accept possible at T1.
REQ-019 MUL: shift-add, multiplier=acc, multiplicand=operand, {acc_hi,lo} 2N product; iteration per cycle: if lo[0], {c,hi}={alu_cout,alu_s} else {0,acc_hi}; then {acc_hi,lo}<={c,hi,lo}>>1.
REQ-020 MUL SHALL run exactly N iterations (counter 0..N-1), commit at edge T0+N: acc<=lo, flag_c<=|acc_hi, flag_z<=(lo==0); done in following cycle.
REQ-021 cmd_valid while busy SHALL be ignored; cmd_op/cmd_data changes while busy SHALL not affect the running op.
REQ-022 Arithmetic SHALL be unsigned modulo 2^N; no sign interpretation inside this block.

Reset
REQ-023 rst_n low at any edge SHALL force IDLE, acc=0, acc_hi=0, flag_z=1, flag_c=0, done=0, err=0, counter=0.
REQ-024 Reset mid-EXEC or mid-MUL SHALL abort without done pulse or partial commit visible after reset.

Configuration
REQ-025 Macro ALU_SEQ_MUL_EN defined: MUL and acc_hi datapath present per REQ-019/020.
REQ-026 Macro ALU_SEQ_MUL_EN undefined: no MUL state/counter; op 8 treated as illegal (REQ-017); acc_hi tied to 0.

Verification
REQ-027 LD 0xF0; ADD 0x20 -> acc=0x10, flag_c=1, flag_z=0, done 1 cycle after commit.
REQ-028 Then ADC 0x00 -> acc=0x11, flag_c=0; SUB 0x11 -> acc=0x00, flag_z=1, flag_c=0.
REQ-029 LD 13; MUL 11 -> after 8 cycles acc=0x8F, acc_hi=0x00, flag_c=0; LD 0xFF; MUL 0xFF -> acc=0x01, acc_hi=0xFE, flag_c=1.
REQ-030 cmd_valid held high with changing cmd_op during MUL -> cmd_ready low for 8 cycles, no extra accept, result unchanged.
REQ-031 rst_n low for one edge during MUL cycle 4 -> acc=0, acc_hi=0, flag_z=1, no done; next LD 0x05 works normally.
REQ-032 Build without ALU_SEQ_MUL_EN, MUL 0x03 with acc=0x07 -> acc stays 0x07, err and done pulse together one cycle.
